// File: rtl/systolic_array.sv
// -----------------------------------------------------------------------------
// systolic_array
//   SIZE x SIZE output-stationary systolic array computing C = A x B for signed
//   square matrices. The host streams operands pre-skewed, one anti-diagonal
//   per clock. Each PE multiplies, accumulates, and forwards its operands east
//   (a) and south (b) with a one-cycle hop. done rises on beat 3*SIZE-2 and is
//   sticky until rst.
//
//   Optional build macro: SA_BOOTH_RADIX8_EN
//     defined   -> each PE uses a factored radix-8 Booth multiplier
//     undefined -> each PE uses a behavioural signed multiply
//   Both builds give bit-identical results and timing.
//
// Ports
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset (clears accumulators, forwards, done)
//   A     west-edge operands, lane i = A[i*DATA_WIDTH +: DATA_WIDTH] -> row i
//   B     north-edge operands, lane j = B[j*DATA_WIDTH +: DATA_WIDTH] -> col j
//   C     results, C_ij = C[(i*SIZE+j)*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   done  high once every C_ij holds its final value
// -----------------------------------------------------------------------------

module systolic_pe #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [DATA_WIDTH-1:0]     a_fwd,
  output logic [DATA_WIDTH-1:0]     b_fwd,
  output logic [2*DATA_WIDTH-1:0]   acc
);

  localparam int ACC_W = 2 * DATA_WIDTH;

  // Multiplicand sign-extended to accumulator width; the product is taken
  // modulo 2^ACC_W, which is exact for a DATA_WIDTH x DATA_WIDTH signed multiply.
  logic [ACC_W-1:0] x1;
  logic [ACC_W-1:0] prod;

  assign x1 = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};

`ifdef SA_BOOTH_RADIX8_EN
  // Radix-8 Booth: overlapping 4-bit windows of the sign-extended multiplier
  // (with an implicit 0 below the LSB) select digits in -4..+4.
  localparam int NPP   = (DATA_WIDTH + 3) / 3;
  localparam int EXT_W = 3 * NPP;

  logic [EXT_W:0]   mult_ext;
  logic [ACC_W-1:0] x2;
  logic [ACC_W-1:0] x3;
  logic [ACC_W-1:0] x4;

  assign mult_ext = {{(EXT_W - DATA_WIDTH){b[DATA_WIDTH-1]}}, b, 1'b0};
  assign x2       = x1 << 1;
  assign x3       = x1 + x2;   // the one hard multiple, shared by all digits
  assign x4       = x1 << 2;

  always_comb begin
    logic [ACC_W-1:0] pp;
    prod = '0;
    pp   = '0;
    for (int k = 0; k < NPP; k++) begin
      case (mult_ext[3*k +: 4])
        4'b0001, 4'b0010: pp = x1;
        4'b0011, 4'b0100: pp = x2;
        4'b0101, 4'b0110: pp = x3;
        4'b0111:          pp = x4;
        4'b1000:          pp = -x4;
        4'b1001, 4'b1010: pp = -x3;
        4'b1011, 4'b1100: pp = -x2;
        4'b1101, 4'b1110: pp = -x1;
        default:          pp = '0;
      endcase
      prod = prod + (pp << (3 * k));
    end
  end
`else
  logic [ACC_W-1:0] y1;

  assign y1 = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};

  always_comb begin
    prod = x1 * y1;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every PE samples
  // its neighbours' pre-edge values; blocking here would collapse the hops.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_fwd <= '0;
      b_fwd <= '0;
      acc   <= '0;
    end else begin
      a_fwd <= a;
      b_fwd <= b;
      acc   <= acc + prod;
    end
  end

endmodule

module systolic_array #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SIZE*DATA_WIDTH-1:0]          A,
  input  logic [SIZE*DATA_WIDTH-1:0]          B,
  output logic [SIZE*SIZE*2*DATA_WIDTH-1:0]   C,
  output logic                                done
);

  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(3 * SIZE - 1);
  localparam logic [CNT_W-1:0] DONE_BEAT = CNT_W'(3 * SIZE - 2);

  // Operand buses: a_bus[i][j] feeds PE(i,j), a_bus[i][j+1] is its east output.
  logic [SIZE:0][DATA_WIDTH-1:0] a_bus [SIZE];
  logic [SIZE:0][DATA_WIDTH-1:0] b_bus [SIZE];

  // Forwards leaving the east and south edges have no consumer.
  logic [SIZE-1:0] unused_edge_a;
  logic [SIZE-1:0] unused_edge_b;

  logic [CNT_W-1:0] beat;

  for (genvar i = 0; i < SIZE; i++) begin : g_edge
    assign a_bus[i][0]   = A[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_bus[i][0]   = B[i*DATA_WIDTH +: DATA_WIDTH];
    assign unused_edge_a[i] = ^a_bus[i][SIZE];
    assign unused_edge_b[i] = ^b_bus[i][SIZE];
  end

  // b_bus is indexed [column][row] so a column's chain sits in one packed word.
  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .a     (a_bus[i][j]),
        .b     (b_bus[j][i]),
        .a_fwd (a_bus[i][j+1]),
        .b_fwd (b_bus[j][i+1]),
        .acc   (C[(i*SIZE+j)*ACC_W +: ACC_W])
      );
    end
  end

  // Beat counter holds the index of the upcoming beat; it saturates at the
  // done beat so done never falls until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
      done <= 1'b0;
    end else begin
      if (beat != DONE_BEAT) begin
        beat <= beat + 1'b1;
      end
      if (beat == DONE_BEAT) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// -----------------------------------------------------------------------------
// tb_systolic_array
//   Directed self-checking bench for systolic_array (SIZE=8, DATA_WIDTH=16).
//   Inputs change on the falling edge; outputs are sampled on the falling edge
//   after the rising edge that produced them. Expected results come from a
//   software signed matmul with 32-bit wrap.
// -----------------------------------------------------------------------------

module tb_systolic_array;

  localparam int SIZE = 8;
  localparam int DW   = 16;
  localparam int AW   = 2 * DW;

  logic                     clk;
  logic                     rst;
  logic [SIZE*DW-1:0]       A;
  logic [SIZE*DW-1:0]       B;
  logic [SIZE*SIZE*AW-1:0]  C;
  logic                     done;

  int n_cmp;
  int n_bad;

  shortint ma [SIZE][SIZE];
  shortint mb [SIZE][SIZE];
  int      ex [SIZE][SIZE];

  systolic_array #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .C    (C),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] c_at(input int i, input int j);
    return C[(i*SIZE+j)*AW +: AW];
  endfunction

  function automatic void compute_expected();
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        int s;
        s = 0;
        for (int m = 0; m < SIZE; m++) s += int'(ma[i][m]) * int'(mb[m][j]);
        ex[i][j] = s;
      end
    end
  endfunction

  // Skewed lanes for beat k: A lane i = A[i][k-i], B lane j = B[k-j][j].
  task automatic drive_beat(input int k);
    for (int l = 0; l < SIZE; l++) begin
      int idx;
      idx = k - l;
      A[l*DW +: DW] = (idx >= 0 && idx < SIZE) ? ma[l][idx] : 16'sd0;
      B[l*DW +: DW] = (idx >= 0 && idx < SIZE) ? mb[idx][l] : 16'sd0;
    end
  endtask

  task automatic check_done(input string tag, input int k, input logic exp_done);
    n_cmp++;
    if (done !== exp_done) begin
      n_bad++;
      $display("FAIL %s done@beat%0d: got %b expected %b", tag, k, done, exp_done);
    end
  endtask

  task automatic check_all_c(input string tag);
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        n_cmp++;
        if (c_at(i, j) !== AW'(ex[i][j])) begin
          n_bad++;
          $display("FAIL %s C[%0d][%0d]: got %h expected %h", tag, i, j, c_at(i, j), AW'(ex[i][j]));
        end
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    n_cmp++;
    if (C !== '0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s cleared: got C_nonzero=%b done=%b expected C_nonzero=0 done=0", tag, (C != '0), done);
    end
  endtask

  // Optionally one reset edge, then 25 beats of skewed stimulus (beats 15+ are
  // zeros). Spot-checks C[0][0] after beats 0 and 7, done around beat 22, and
  // every C_ij at the end.
  task automatic run_job(input string tag, input bit with_reset);
    compute_expected();
    if (with_reset) begin
      @(negedge clk);
      rst = 1'b1;
      A = '0;
      B = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      drive_beat(k);
      @(negedge clk);
      if (k == 0) begin
        n_cmp++;
        if (c_at(0, 0) !== AW'(int'(ma[0][0]) * int'(mb[0][0]))) begin
          n_bad++;
          $display("FAIL %s C00@beat0: got %h expected %h", tag, c_at(0, 0),
                   AW'(int'(ma[0][0]) * int'(mb[0][0])));
        end
      end
      if (k == 7) begin
        n_cmp++;
        if (c_at(0, 0) !== AW'(ex[0][0])) begin
          n_bad++;
          $display("FAIL %s C00@beat7: got %h expected %h", tag, c_at(0, 0), AW'(ex[0][0]));
        end
      end
      if (k == 21) check_done(tag, k, 1'b0);
      if (k == 22) check_done(tag, k, 1'b1);
      if (k == 24) check_done(tag, k, 1'b1);
    end
    check_all_c(tag);
  endtask

  task automatic load_identity();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        ma[i][j] = (i == j) ? 16'sd1 : 16'sd0;
        mb[i][j] = shortint'(i * 8 + j + 1);
      end
  endtask

  task automatic test_reset();
    bit seen_nonzero;
    rst = 1'b1;
    A = {$urandom, $urandom, $urandom, $urandom};
    B = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    @(negedge clk);
    check_cleared("reset_hold");
    rst = 1'b0;
    A = '0;
    B = '0;
    seen_nonzero = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (C != '0) seen_nonzero = 1'b1;
      if (k == 21 || k == 22 || k == 29) check_done("reset_zeros", k, k >= 22);
    end
    n_cmp++;
    if (seen_nonzero) begin
      n_bad++;
      $display("FAIL reset_zeros C_stable: got nonzero expected all zero");
    end
  endtask

  task automatic test_identity();
    load_identity();
    run_job("identity", 1'b1);
    n_cmp++;
    if (c_at(7, 7) !== 32'd64) begin
      n_bad++;
      $display("FAIL identity C77: got %h expected %h", c_at(7, 7), 32'd64);
    end
  endtask

  task automatic test_reference();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        ma[i][j] = shortint'(((i * 37 + j * 11 + 5) % 200) - 100);
        mb[i][j] = shortint'(((i * 13 + j * 29 + 3) % 250) - 125);
      end
    ma[0][0] = 37; mb[0][0] = 2;
    ma[1][0] = 45; ma[0][1] = 60;
    mb[0][1] = 30; mb[1][0] = 47;
    run_job("reference", 1'b1);
  endtask

  task automatic test_signed_wrap();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        ma[i][j] = -16'sd32768;
        mb[i][j] = -16'sd32768;
      end
    run_job("wrap_min", 1'b1);
    n_cmp++;
    if (c_at(3, 5) !== 32'h0000_0000) begin
      n_bad++;
      $display("FAIL wrap_min C35: got %h expected %h", c_at(3, 5), 32'h0000_0000);
    end
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        ma[i][j] = -16'sd1;
        mb[i][j] = 16'sd1;
      end
    run_job("neg_one", 1'b1);
    n_cmp++;
    if (c_at(6, 2) !== 32'hFFFF_FFF8) begin
      n_bad++;
      $display("FAIL neg_one C62: got %h expected %h", c_at(6, 2), 32'hFFFF_FFF8);
    end
  endtask

  task automatic test_mid_op_reset();
    load_identity();
    @(negedge clk);
    rst = 1'b1;
    A = '0;
    B = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_beat(k);
      @(negedge clk);
    end
    n_cmp++;
    if (c_at(0, 0) !== 32'd1) begin
      n_bad++;
      $display("FAIL midop partial C00@beat9: got %h expected %h", c_at(0, 0), 32'd1);
    end
    rst = 1'b1;
    drive_beat(10);
    @(negedge clk);
    check_cleared("midop_reset");
    run_job("midop_restart", 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) begin
          ma[i][j] = shortint'($urandom);
          mb[i][j] = shortint'($urandom);
        end
      run_job($sformatf("random%0d", t), 1'b1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    A     = '0;
    B     = '0;
    test_reset();
    test_identity();
    test_reference();
    test_signed_wrap();
    test_mid_op_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- SIZE x SIZE output-stationary systolic array that computes C = A x B for two square signed matrices.
- Operands are streamed in pre-skewed, one anti-diagonal per clock.
- Each processing element (PE) multiplies, accumulates, and forwards its operands east and south.
- Used as the matrix-multiply core; the host owns operand skewing and reads all SIZE*SIZE results in parallel once done rises.

Parameters:
- SIZE, 8: array dimension; matrices are SIZE x SIZE.
- DATA_WIDTH, 16: operand width in bits, signed two's complement; each accumulator is 2*DATA_WIDTH bits.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  SIZE*DATA_WIDTH  west-edge operands; lane i = A[i*DATA_WIDTH +: DATA_WIDTH] feeds row i.
- B  input  SIZE*DATA_WIDTH  north-edge operands; lane j = B[j*DATA_WIDTH +: DATA_WIDTH] feeds column j.
- C  output  SIZE*SIZE*2*DATA_WIDTH  result; C_ij = C[(i*SIZE+j)*2*DATA_WIDTH +: 2*DATA_WIDTH].
- done  output  1  high once every C_ij holds its final value.

Behaviour:
- Reset: when rst=1 at a rising edge, clear all PE accumulators, all forwarded a/b registers, the beat counter and done. C = 0 and done = 0 from that edge. Reset mid-operation discards the partial results.
- Beat numbering: beat 0 is the first rising edge with rst=0 after reset; the counter increments once per beat.
- Input skew (host duty): at beat k, lane i of A carries A[i][k-i] and lane j of B carries B[k-j][j]. Out-of-range indices carry 0. Feeding runs for beats 0..2*SIZE-2, then zeros.
- PE(i,j) datapath:
  - a input: lane i for j=0, else the registered a of PE(i,j-1).
  - b input: lane j for i=0, else the registered b of PE(i-1,j).
  - Each edge: acc <= acc + a*b; register a and b for forwarding. One-cycle hop per PE.
- Timing: product A[i][m]*B[m][j] is accumulated at beat m+i+j. C_ij is final after beat i+j+SIZE-1. C[SIZE-1][SIZE-1] is final after beat 3*SIZE-3.
- Arithmetic:
  - a*b is a signed DATA_WIDTH x DATA_WIDTH multiply giving a full 2*DATA_WIDTH product.
  - The accumulator is 2*DATA_WIDTH bits and wraps modulo 2^(2*DATA_WIDTH); there is no saturation or overflow flag.
- C is driven directly from the accumulator registers (no extra output stage). Partial sums are visible while computing.
- done:
  - Registered; rises at beat 3*SIZE-2 (beat 22 for SIZE=8), i.e. the edge after the last accumulation.
  - Sticky until rst. The counter saturates and never wraps.
  - Accumulation continues after done, so the host must keep driving zeros to hold C stable.
- A new multiply requires a reset between jobs; no back-to-back overlap.

Optional Feature:
- Macro SA_BOOTH_RADIX8_EN.
- When defined: each PE multiplier is a factored radix-8 Booth multiplier.
  - Digits are taken from overlapping 4-bit groups of the sign-extended multiplier, giving ceil((DATA_WIDTH+1)/3) partial products.
  - Multiplicand multiples are 0, ±1x, ±2x, ±3x, ±4x; 3x is precomputed once per PE as x+2x.
  - Partial products are summed combinationally within the same cycle.
- When undefined: the multiplier is a behavioural signed `*`.
- Results, latency and done timing are bit-identical in both builds.

Test Plan:
- Reset check: hold rst=1 for 2 edges with random A/B -> C=0 and done=0. Release and drive zeros for 30 beats -> C stays 0; done rises exactly at beat 22 and stays high.
- Identity: A = I, B[m][j] = m*8+j+1, skewed -> C[i][j] = B[i][j] (e.g. C[7][7]=64); C[0][0] is final after beat 7.
- Reference stream (SIZE=8): beat0 A lane0=37, B lane0=2; beat1 A lanes{1,0}={45,60}, B lanes{1,0}={30,47}; continue the full 8x8 skewed stream, then zeros -> every C_ij equals a software signed matmul by beat 22, with done=1.
- Signed/wrap: all A=-32768, all B=-32768 -> each product is 2^30; each C_ij = 8*2^30 mod 2^32 = 0x0000_0000 (wraps). With all A=-1 and all B=1 -> each C_ij = 0xFFFF_FFF8.
- Mid-op reset: assert rst at beat 10 for one edge -> C and done clear on that edge. Restart with the identity stimulus -> correct results and done at beat 22 from the new beat 0.
- Build with and without SA_BOOTH_RADIX8_EN; run 1000 random signed matrices -> identical C and done traces across the two builds.
